// File: rtl/uart_rx_only.sv
// uart_rx_only: 8N1 UART receiver with fractional 16x oversampling, majority vote and ready/read holding register
module uart_rx_only #(
  parameter int CLK_HZ = 68000000,
  parameter int BAUD   = 115200,
  parameter int ACC_W  = 32
) (
  input  logic       sys_clk_i,
  input  logic       sys_rst_n_i,
  input  logic       uart_rx,
  input  logic       uart_rd_i,
  output logic [7:0] uart_dat_o,
  output logic       uart_rdy_o,
  output logic       uart_frame_err_o,
  output logic       uart_overrun_o,
  output logic       uart_rx_busy_o
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  localparam logic [ACC_W-1:0] INC = ACC_W'(16 * BAUD);
  localparam logic [ACC_W-1:0] LIM = ACC_W'(CLK_HZ);

  state_t           state_q, state_d;
  logic             rx_m_q, rx_s_q;
  logic [ACC_W-1:0] acc_q, acc_d, sum;
  logic             tick;
  logic [3:0]       cnt_q, cnt_d;
  logic [1:0]       smp_q, smp_d;
  logic             vote_q, vote_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shr_q, shr_d;
  logic [7:0]       dat_q, dat_d;
  logic             rdy_q, rdy_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             busy_q, busy_d;
  logic             maj, vote_tick, end_tick, load;

  // fractional 16x baud tick: add 16*BAUD each cycle, wrap at CLK_HZ
  always_comb begin
    sum   = acc_q + INC;
    tick  = sum >= LIM;
    acc_d = tick ? sum - LIM : sum;
  end

  // receive FSM next state, mid-bit vote and holding register update
  always_comb begin
    maj       = (smp_q[0] & smp_q[1]) | (rx_s_q & (smp_q[0] | smp_q[1]));
    vote_tick = tick && cnt_q == 4'd9;
    end_tick  = tick && cnt_q == 4'd15;
    state_d   = state_q;
    cnt_d     = tick ? cnt_q + 4'd1 : cnt_q;
    smp_d     = {(tick && cnt_q == 4'd8) ? rx_s_q : smp_q[1], (tick && cnt_q == 4'd7) ? rx_s_q : smp_q[0]};
    vote_d    = vote_tick ? maj : vote_q;
    idx_d     = idx_q;
    shr_d     = shr_q;
    load      = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      IDLE: if (!rx_s_q) begin
        state_d = START;
        cnt_d   = '0;
        smp_d   = '0;
        vote_d  = 1'b0;
      end
      START: if (end_tick) begin
        state_d = vote_q ? IDLE : DATA;
        idx_d   = '0;
      end
      DATA: if (end_tick) begin
        shr_d   = {vote_q, shr_q[7:1]};
        idx_d   = idx_q + 3'd1;
        state_d = (idx_q == 3'd7) ? STOP : DATA;
      end
      STOP: if (vote_tick) begin
        state_d = maj ? IDLE : WAIT_HIGH;
        load    = maj;
        ferr_d  = ~maj;
      end
      WAIT_HIGH: state_d = rx_s_q ? IDLE : WAIT_HIGH;
      default: state_d = IDLE;
    endcase
    dat_d  = load ? shr_q : dat_q;
    rdy_d  = load | (rdy_q & ~uart_rd_i);
    ovr_d  = load & rdy_q & ~uart_rd_i;
    busy_d = state_d != IDLE;
  end

  // synchronizer, tick accumulator, FSM and registered outputs
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      rx_m_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      acc_q   <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      smp_q   <= '0;
      vote_q  <= 1'b0;
      idx_q   <= '0;
      shr_q   <= '0;
      dat_q   <= '0;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      rx_m_q  <= uart_rx;
      rx_s_q  <= rx_m_q;
      acc_q   <= acc_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      smp_q   <= smp_d;
      vote_q  <= vote_d;
      idx_q   <= idx_d;
      shr_q   <= shr_d;
      dat_q   <= dat_d;
      rdy_q   <= rdy_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign uart_dat_o       = dat_q;
  assign uart_rdy_o       = rdy_q;
  assign uart_frame_err_o = ferr_q;
  assign uart_overrun_o   = ovr_q;
  assign uart_rx_busy_o   = busy_q;

endmodule

// File: tb/tb_uart_rx_only.sv
// tb_uart_rx_only: scoreboard bench for the 8N1 receiver with nominal and +/-3% transmitters
module tb_uart_rx_only;

  localparam int CLK_HZ = 34000000;
  localparam int BAUD   = 115200;
  localparam int BIT    = CLK_HZ / BAUD;
  localparam int FAST   = 286;
  localparam int SLOW   = 304;
  localparam logic [31:0] INC = 32'(16 * BAUD);
  localparam logic [31:0] LIM = 32'(CLK_HZ);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] dat;
  logic       rdy, ferr, ovr, busy;

  int total = 0;
  int bad = 0;
  int ferr_n = 0;
  int ovr_n = 0;
  logic [7:0] exp_q[$];
  logic       rdy_p = 1'b0;
  logic [7:0] dat_p = 8'h00;
  logic [31:0] m_acc;
  logic        m_tick;

  uart_rx_only #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ACC_W(32)) dut (
    .sys_clk_i(clk),
    .sys_rst_n_i(rst_n),
    .uart_rx(rx),
    .uart_rd_i(rd),
    .uart_dat_o(dat),
    .uart_rdy_o(rdy),
    .uart_frame_err_o(ferr),
    .uart_overrun_o(ovr),
    .uart_rx_busy_o(busy)
  );

  always #5 clk = ~clk;

  // reference tick phase, used only to place uart_rd_i on a chosen cycle
  assign m_tick = (m_acc + INC) >= LIM;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) m_acc <= '0;
    else m_acc <= m_tick ? m_acc + INC - LIM : m_acc + INC;

  // scoreboard: every byte load is popped and compared against the queue
  always @(negedge clk) begin
    if (ferr) ferr_n++;
    if (ovr) ovr_n++;
    if (rdy && (!rdy_p || dat != dat_p || ovr)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected got=%02h want=none", dat);
      end else begin
        if (dat !== exp_q[0]) begin
          bad++;
          $display("FAIL sb_byte got=%02h want=%02h", dat, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
    rdy_p = rdy;
    dat_p = dat;
  end

  task automatic send_frame(input logic [7:0] b, input logic stop, input int per);
    rx = 1'b0;
    repeat (per) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (per) @(negedge clk);
    end
    rx = stop;
    repeat (per) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (dat !== 8'h00) begin bad++; $display("FAIL rst_dat got=%02h want=00", dat); end
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL rst_rdy got=%b want=0", rdy); end
    total++; if (ferr !== 1'b0) begin bad++; $display("FAIL rst_ferr got=%b want=0", ferr); end
    total++; if (ovr !== 1'b0) begin bad++; $display("FAIL rst_ovr got=%b want=0", ovr); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    total++; if ({rdy, busy} !== 2'b00) begin bad++; $display("FAIL idle_after_rst got=%b%b want=00", rdy, busy); end
  endtask

  task automatic test_basic();
    int t;
    t = 0;
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1, BIT);
      begin
        while (!rdy && t < 12 * BIT) begin @(negedge clk); t++; end
        total++; if (t < 93 * BIT / 10 || t > 98 * BIT / 10) begin bad++; $display("FAIL latency got=%0d want=%0d..%0d", t, 93 * BIT / 10, 98 * BIT / 10); end
        total++; if (dat !== 8'hA5) begin bad++; $display("FAIL basic_dat got=%02h want=a5", dat); end
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        total++; if (rdy !== 1'b0) begin bad++; $display("FAIL rd_clear got=%b want=0", rdy); end
      end
    join
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL basic_drain got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_glitch();
    int f0;
    f0 = ferr_n;
    rx = 1'b0;
    repeat (40) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch_start got=%b want=1", busy); end
    rx = 1'b1;
    repeat (3 * BIT / 2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_idle got=%b want=0", busy); end
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL glitch_rdy got=%b want=0", rdy); end
    total++; if (ferr_n != f0) begin bad++; $display("FAIL glitch_ferr got=%0d want=%0d", ferr_n, f0); end
  endtask

  task automatic test_frame_err();
    int f0;
    f0 = ferr_n;
    send_frame(8'h3C, 1'b0, BIT);
    repeat (20 * BIT) @(negedge clk);
    total++; if (ferr_n != f0 + 1) begin bad++; $display("FAIL break_ferr got=%0d want=%0d", ferr_n, f0 + 1); end
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL break_rdy got=%b want=0", rdy); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL break_wait got=%b want=1", busy); end
    rx = 1'b1;
    repeat (BIT) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL break_idle got=%b want=0", busy); end
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, BIT);
    total++; if (ferr_n != f0 + 1) begin bad++; $display("FAIL break_once got=%0d want=%0d", ferr_n, f0 + 1); end
    total++; if ({rdy, dat} !== 9'h155) begin bad++; $display("FAIL after_break got=%b/%02h want=1/55", rdy, dat); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL break_drain got=%0d want=0", exp_q.size()); end
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic test_overrun();
    int o0, t, k;
    logic dropped;
    o0 = ovr_n;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, BIT);
    exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b1, BIT);
    repeat (4) @(negedge clk);
    total++; if (ovr_n != o0 + 1) begin bad++; $display("FAIL ovr_count got=%0d want=%0d", ovr_n, o0 + 1); end
    total++; if ({rdy, dat} !== 9'h122) begin bad++; $display("FAIL ovr_data got=%b/%02h want=1/22", rdy, dat); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL ovr_drain got=%0d want=0", exp_q.size()); end
    o0 = ovr_n;
    t = 0;
    k = 0;
    dropped = 1'b0;
    exp_q.push_back(8'h33);
    fork
      send_frame(8'h33, 1'b1, BIT);
      begin
        while (!busy && t < 3 * BIT) begin @(negedge clk); t++; end
        while (t < 12 * BIT) begin
          if (m_tick) k++;
          if (k == 154) break;
          @(negedge clk);
          t++;
          if (!rdy) dropped = 1'b1;
        end
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        total++; if ({rdy, dat} !== 9'h133) begin bad++; $display("FAIL rd_load_data got=%b/%02h want=1/33", rdy, dat); end
      end
    join
    total++; if (k != 154) begin bad++; $display("FAIL rd_load_timing got=%0d want=154", k); end
    total++; if (dropped !== 1'b0) begin bad++; $display("FAIL rd_load_rdy_dip got=%b want=0", dropped); end
    total++; if (ovr_n != o0) begin bad++; $display("FAIL rd_load_ovr got=%0d want=%0d", ovr_n, o0); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rd_load_drain got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_reset_midframe();
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
    repeat (4 * BIT + BIT / 2) @(negedge clk);
    total++; if ({busy, rdy} !== 2'b11) begin bad++; $display("FAIL mid_frame got=%b%b want=11", busy, rdy); end
    rst_n = 1'b0;
    #1;
    total++; if ({dat, rdy, ferr, ovr, busy} !== 12'h000) begin bad++; $display("FAIL rst_mid got=%02h/%b%b%b%b want=00/0000", dat, rdy, ferr, ovr, busy); end
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, BIT);
    total++; if ({rdy, dat} !== 9'h181) begin bad++; $display("FAIL rst_next got=%b/%02h want=1/81", rdy, dat); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rst_drain got=%0d want=0", exp_q.size()); end
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic test_back_to_back(input int per);
    int f0, o0, n, t;
    f0 = ferr_n;
    o0 = ovr_n;
    n = 0;
    t = 0;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h5A);
    fork
      begin
        send_frame(8'h00, 1'b1, per);
        send_frame(8'hFF, 1'b1, per);
        send_frame(8'h5A, 1'b1, per);
      end
      begin
        while (n < 3 && t < 40 * per) begin
          @(negedge clk);
          t++;
          if (rdy) begin
            rd = 1'b1;
            @(negedge clk);
            rd = 1'b0;
            t++;
            n++;
          end
        end
      end
    join
    repeat (4) @(negedge clk);
    total++; if (n != 3) begin bad++; $display("FAIL b2b_count per=%0d got=%0d want=3", per, n); end
    total++; if (ferr_n != f0) begin bad++; $display("FAIL b2b_ferr per=%0d got=%0d want=%0d", per, ferr_n, f0); end
    total++; if (ovr_n != o0) begin bad++; $display("FAIL b2b_ovr per=%0d got=%0d want=%0d", per, ovr_n, o0); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_drain per=%0d got=%0d want=0", per, exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_midframe();
    test_back_to_back(FAST);
    test_back_to_back(SLOW);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
